eth_framer: RTL

Packs 40-bit ADC sample words (four 10-bit samples) from the clock-crossing FIFO into Ethernet II frames. Emits one byte per clk125 cycle to the RGMII transmit serializer. Sits between the FIFO read port (clk125 side) and the RGMII DDR output stage. Generates the preamble/SFD, a fixed header, the sequence number, the payload and the CRC-32 FCS, and enforces the inter-frame gap.

---
 rtl/eth_pkg.sv | 33 +++
 rtl/crc32_d8.sv | 23 ++
 rtl/eth_framer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared types, constants and the byte-wide CRC-32 step for the Ethernet
// framer and the receive-side FCS checker.
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        HDR,
        PAY,
        FCS,
        IFG
    } state_t;

    localparam logic [7:0]  PREAMBLE = 8'h55;
    localparam logic [7:0]  SFD      = 8'hD5;
    localparam int          PRE_LEN  = 8;
    localparam int          HDR_LEN  = 16;
    localparam int          FCS_LEN  = 4;
    localparam int          IFG_LEN  = 12;
    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    // Reflected CRC-32: one byte, LSB first, eight shift/xor steps.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h000000, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide IEEE 802.3 CRC-32 accumulator; init has priority over en.
module crc32_d8
    import eth_pkg::*;
(
    input  logic        clk125,
    input  logic        rstn,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  d,
    output logic [31:0] crc
);

    always_ff @(posedge clk125 or negedge rstn) begin
        if (!rstn) begin
            crc <= CRC_INIT;
        end else if (init) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc32_byte(crc, d);
        end
    end

endmodule

// File: rtl/eth_framer.sv
// Packs 40-bit FIFO words into Ethernet II frames, one byte per clk125 cycle,
// with preamble/SFD, fixed header, sequence number, FCS and inter-frame gap.
module eth_framer
    import eth_pkg::*;
#(
    parameter int          WORDS   = 256,
    parameter logic [47:0] DST_MAC = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC = 48'h0200_0000_0001,
    parameter logic [15:0] ETYPE   = 16'h88B5
) (
    input  logic        clk125,
    input  logic        rstn,
    input  logic        fifo_rdy,
    input  logic        fifo_empty,
    input  logic [39:0] fifo_q,
    output logic        fifo_rden,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    output logic        err_underflow,
    output logic [15:0] frame_cnt
);

    localparam logic [15:0] PAY_LAST  = 16'(WORDS * 5 - 1);
    localparam logic [8:0]  WORD_LAST = 9'(WORDS - 1);

    state_t       state_reg, state_next;
    logic [15:0]  cnt_reg, cnt_next;
    logic [2:0]   bcnt_reg;
    logic [8:0]   widx_reg;
    logic [15:0]  seq_reg;
    logic [39:0]  sreg_reg;
    logic         rd_slot_reg, rd_ok_reg;
    logic         rd_due, frame_done, tx_en_next;
    logic [7:0]   byte_next;
    logic [31:0]  crc_val;
    logic         crc_init, crc_en;
    logic [127:0] hdr_vec;
    logic [7:0]   hdr_bytes [16];
    logic [7:0]   fcs_bytes [4];

    assign hdr_vec = {DST_MAC, SRC_MAC, ETYPE, seq_reg};

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_hdr
            assign hdr_bytes[gi] = hdr_vec[127 - 8 * gi -: 8];
        end
        for (gi = 0; gi < 4; gi++) begin : g_fcs
            assign fcs_bytes[gi] = ~crc_val[8 * gi +: 8];
        end
    endgenerate

    // Reads lead the first byte of their word by 3 cycles: word 0 is fetched
    // in HDR byte 13, word w+1 in byte 2 of word w.
    assign rd_due = ((state_reg == HDR) && (cnt_reg == 16'(HDR_LEN - 3))) ||
                    ((state_reg == PAY) && (bcnt_reg == 3'd2) && (widx_reg != WORD_LAST));
    assign fifo_rden = rd_due & ~fifo_empty;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 16'd1;
        frame_done = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (fifo_rdy) state_next = PRE;
            end
            PRE: if (cnt_reg == 16'(PRE_LEN - 1)) begin state_next = HDR; cnt_next = '0; end
            HDR: if (cnt_reg == 16'(HDR_LEN - 1)) begin state_next = PAY; cnt_next = '0; end
            PAY: if (cnt_reg == PAY_LAST)         begin state_next = FCS; cnt_next = '0; end
            FCS: if (cnt_reg == 16'(FCS_LEN - 1)) begin
                state_next = IFG;
                cnt_next   = '0;
                frame_done = 1'b1;
            end
            IFG: if (cnt_reg == 16'(IFG_LEN - 1)) begin state_next = IDLE; cnt_next = '0; end
            default: begin state_next = IDLE; cnt_next = '0; end
        endcase
    end

    // Output byte is chosen from the next state so that tx_data/tx_en are
    // registered yet aligned with the state register.
    always_comb begin
        byte_next  = 8'h00;
        tx_en_next = 1'b0;
        case (state_next)
            PRE: begin
                tx_en_next = 1'b1;
                byte_next  = (cnt_next == 16'(PRE_LEN - 1)) ? SFD : PREAMBLE;
            end
            HDR: begin tx_en_next = 1'b1; byte_next = hdr_bytes[cnt_next[3:0]]; end
            PAY: begin tx_en_next = 1'b1; byte_next = sreg_reg[39:32]; end
            FCS: begin tx_en_next = 1'b1; byte_next = fcs_bytes[cnt_next[1:0]]; end
            default: ;
        endcase
    end

    assign crc_init = (state_next == PRE);
    assign crc_en   = (state_next == HDR) || (state_next == PAY);

    crc32_d8 u_crc (
        .clk125 (clk125),
        .rstn   (rstn),
        .init   (crc_init),
        .en     (crc_en),
        .d      (byte_next),
        .crc    (crc_val)
    );

    always_ff @(posedge clk125 or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bcnt_reg      <= '0;
            widx_reg      <= '0;
            seq_reg       <= '0;
            sreg_reg      <= '0;
            rd_slot_reg   <= 1'b0;
            rd_ok_reg     <= 1'b0;
            tx_data       <= '0;
            tx_en         <= 1'b0;
            err_underflow <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            tx_data     <= byte_next;
            tx_en       <= tx_en_next;
            rd_slot_reg <= rd_due;
            rd_ok_reg   <= rd_due & ~fifo_empty;

            if (state_reg != PAY) begin
                bcnt_reg <= '0;
                widx_reg <= '0;
            end else if (bcnt_reg == 3'd4) begin
                bcnt_reg <= '0;
                widx_reg <= widx_reg + 9'd1;
            end else begin
                bcnt_reg <= bcnt_reg + 3'd1;
            end

            // A missed read still occupies its slot, carrying an all-zero word.
            if (rd_slot_reg) begin
                sreg_reg <= rd_ok_reg ? fifo_q : 40'h0;
            end else if (state_next == PAY) begin
                sreg_reg <= {sreg_reg[31:0], 8'h00};
            end

            if (rd_due && fifo_empty) err_underflow <= 1'b1;

            if (frame_done) begin
                seq_reg   <= seq_reg + 16'd1;
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule
